// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
//   loader_state_e  : loader FSM states
//   LOADER_BYTE_W   : width of one stream byte
//   LOADER_CKSUM_W  : width of the image checksum accumulator
package loader_pkg;

  localparam int unsigned LOADER_BYTE_W  = 8;
  localparam int unsigned LOADER_CKSUM_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StGetCnt,
    StGetHi,
    StGetLo,
    StWrite,
    StCheck,
    StStart,
    StError
  } loader_state_e;

endpackage

// File: rtl/loader_cksum.sv
// Running 8-bit checksum over the accepted stream bytes.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the sum at zero (new load)
//   add        : a byte is accepted this cycle
//   data       : the byte being accepted
//   ok         : sum, including any byte added this cycle, is zero
module loader_cksum
  import loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     add,
  input  logic [LOADER_BYTE_W-1:0] data,
  output logic                     ok
);

  logic [LOADER_CKSUM_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (add) begin
      sum_d = sum_q + LOADER_CKSUM_W'(data);
    end
  end

  // Looks through the byte being added so the FSM can decide in the same
  // cycle that it accepts the checksum byte.
  assign ok = (sum_d == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader for the six-instruction processor.
// Receives: count byte N (0 = full depth), N words high byte first, and,
// when PROGRAM_LOADER_CHECKSUM_EN is defined, a trailing checksum byte that
// makes the 8-bit sum of the whole image zero.
//   clk, reset            : clock, asynchronous active-high reset
//   load_req              : begin a load (ignored while busy)
//   in_data/valid/ready   : byte stream handshake
//   i_wr_en/addr/data     : instruction-memory write port
//   proc_reset, start     : processor hold and one-cycle release pulse
//   busy, done, error     : load status (done/error sticky until load_req)
//   words_loaded          : words written in the current/last load
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_req,
  input  logic [LOADER_BYTE_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     i_wr_en,
  output logic [ADDR_W-1:0]        i_wr_addr,
  output logic [DATA_W-1:0]        i_wr_data,
  output logic                     proc_reset,
  output logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [ADDR_W:0]          words_loaded
);

  loader_state_e state_q, state_d;

  logic [ADDR_W:0]            cnt_q, cnt_d;
  logic [ADDR_W:0]            words_q, words_d;
  logic [LOADER_BYTE_W-1:0]   hi_q, hi_d;
  logic                       wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]          wr_data_q, wr_data_d;
  logic                       proc_reset_q, proc_reset_d;
  logic                       start_q, start_d;
  logic                       done_q, done_d;
  logic                       accept;

  // Count byte 0 means 256 words; anything beyond the memory depth is clipped
  // so the write address can never wrap.
  function automatic logic [ADDR_W:0] count_decode(input logic [LOADER_BYTE_W-1:0] b);
    int unsigned n;
    n = (b == '0) ? 32'd256 : 32'(b);
    if (n > (32'd1 << ADDR_W)) n = 32'd1 << ADDR_W;
    return n[ADDR_W:0];
  endfunction

  // Moore decodes of the state register only: no input-to-output path.
  assign in_ready = (state_q == StGetCnt) || (state_q == StGetHi) ||
                    (state_q == StGetLo)  || (state_q == StCheck);
  assign busy     = (state_q != StIdle);
  assign accept   = in_valid && in_ready;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic error_q, error_d;
  logic cks_ok;

  loader_cksum u_cksum (
    .clk   (clk),
    .reset (reset),
    .clear ((state_q == StIdle) && load_req),
    .add   (accept),
    .data  (in_data),
    .ok    (cks_ok)
  );
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    words_d      = words_q;
    hi_d         = hi_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    proc_reset_d = proc_reset_q;
    start_d      = 1'b0;
    done_d       = done_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    error_d      = error_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (load_req) begin
          state_d      = StGetCnt;
          done_d       = 1'b0;
          words_d      = '0;
          proc_reset_d = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          error_d      = 1'b0;
`endif
        end
      end
      StGetCnt: begin
        if (accept) begin
          cnt_d   = count_decode(in_data);
          state_d = StGetHi;
        end
      end
      StGetHi: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = StGetLo;
        end
      end
      StGetLo: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = words_q[ADDR_W-1:0];
          wr_data_d = DATA_W'({hi_q, in_data});
          state_d   = StWrite;
        end
      end
      StWrite: begin
        words_d = words_q + 1'b1;
        if (words_d == cnt_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d      = StCheck;
`else
          state_d      = StStart;
          start_d      = 1'b1;
          proc_reset_d = 1'b0;
`endif
        end else begin
          state_d = StGetHi;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) begin
          if (cks_ok) begin
            state_d      = StStart;
            start_d      = 1'b1;
            proc_reset_d = 1'b0;
          end else begin
            state_d = StError;
          end
        end
      end
      StError: begin
        error_d = 1'b1;
        state_d = StIdle;
      end
`endif
      StStart: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      words_q      <= '0;
      hi_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      proc_reset_q <= 1'b1;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      words_q      <= words_d;
      hi_q         <= hi_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      proc_reset_q <= proc_reset_d;
      start_q      <= start_d;
      done_q       <= done_d;
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign i_wr_en      = wr_en_q;
  assign i_wr_addr    = wr_addr_q;
  assign i_wr_data    = wr_data_q;
  assign proc_reset   = proc_reset_q;
  assign start        = start_q;
  assign done         = done_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_req;
  logic [7:0] in_data;
  logic       in_valid;
  logic       sel;  // 0: 256-deep instance, 1: 16-deep instance

  // 256-deep instance
  logic        in_ready8, wr_en8, proc_reset8, start8, busy8, done8, error8;
  logic [7:0]  wr_addr8;
  logic [15:0] wr_data8;
  logic [8:0]  words8;
  // 16-deep instance
  logic        in_ready4, wr_en4, proc_reset4, start4, busy4, done4, error4;
  logic [3:0]  wr_addr4;
  logic [15:0] wr_data4;
  logic [4:0]  words4;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(8), .DATA_W(16)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .load_req     (load_req & ~sel),
    .in_data      (in_data),
    .in_valid     (in_valid & ~sel),
    .in_ready     (in_ready8),
    .i_wr_en      (wr_en8),
    .i_wr_addr    (wr_addr8),
    .i_wr_data    (wr_data8),
    .proc_reset   (proc_reset8),
    .start        (start8),
    .busy         (busy8),
    .done         (done8),
    .error        (error8),
    .words_loaded (words8)
  );

  program_loader #(.ADDR_W(4), .DATA_W(16)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .load_req     (load_req & sel),
    .in_data      (in_data),
    .in_valid     (in_valid & sel),
    .in_ready     (in_ready4),
    .i_wr_en      (wr_en4),
    .i_wr_addr    (wr_addr4),
    .i_wr_data    (wr_data4),
    .proc_reset   (proc_reset4),
    .start        (start4),
    .busy         (busy4),
    .done         (done4),
    .error        (error4),
    .words_loaded (words4)
  );

  // View of the selected instance
  logic        c_ready, c_wr_en, c_pr, c_start, c_busy, c_done, c_error;
  logic [7:0]  c_addr;
  logic [15:0] c_data;
  logic [8:0]  c_words;
  assign c_ready = sel ? in_ready4   : in_ready8;
  assign c_wr_en = sel ? wr_en4      : wr_en8;
  assign c_pr    = sel ? proc_reset4 : proc_reset8;
  assign c_start = sel ? start4      : start8;
  assign c_busy  = sel ? busy4       : busy8;
  assign c_done  = sel ? done4       : done8;
  assign c_error = sel ? error4      : error8;
  assign c_addr  = sel ? {4'h0, wr_addr4} : wr_addr8;
  assign c_data  = sel ? wr_data4    : wr_data8;
  assign c_words = sel ? {4'h0, words4}   : words8;

  int unsigned n_asserts = 0;
  int unsigned n_fails   = 0;
  int unsigned start_cnt = 0;
  logic        prev_pr   = 1'b1;
  bit          toggle_mode = 0;
  bit          poke_req    = 0;
  logic [23:0] exp_q[$];     // {addr, data} expected writes in order
  logic [15:0] prog[$];      // words of the image being sent

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write and start pulse of the selected instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (c_wr_en) begin
        chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [23:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(c_addr), 32'(e[23:16]));
          chk("wr_data", 32'(c_data), 32'(e[15:0]));
        end
      end
      if (c_start) begin
        start_cnt++;
        chk("start_proc_reset_low", 32'(c_pr), 32'd0);
        chk("start_first_release", 32'(prev_pr), 32'd1);
      end
      prev_pr = c_pr;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!c_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!c_ready) chk("ready_timeout", 32'(c_ready), 32'd1);
    @(negedge clk);  // accepted on the intervening rising edge
    if (toggle_mode) begin
      in_valid = 1'b0;
      load_req = poke_req;
      @(negedge clk);
      load_req = 1'b0;
    end
  endtask

  task automatic pulse_load;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] cnt_byte, input bit bad_ck);
    logic [7:0] sum;
    sum = cnt_byte;
    start_cnt = 0;
    pulse_load();
    send_byte(cnt_byte);
    for (int i = 0; i < prog.size(); i++) begin
      exp_q.push_back({8'(i), prog[i]});
      send_byte(prog[i][15:8]);
      send_byte(prog[i][7:0]);
      sum = sum + prog[i][15:8] + prog[i][7:0];
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(bad_ck ? 8'h00 : 8'(8'h00 - sum));
`else
    if (bad_ck) sum = 8'h00;
`endif
    in_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (c_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(c_busy), 32'd0);
  endtask

  task automatic check_ok_load(input string tag, input int unsigned nwords);
    chk({tag, "_starts"}, start_cnt, 32'd1);
    chk({tag, "_done"}, 32'(c_done), 32'd1);
    chk({tag, "_error"}, 32'(c_error), 32'd0);
    chk({tag, "_proc_reset"}, 32'(c_pr), 32'd0);
    chk({tag, "_words"}, 32'(c_words), nwords);
    chk({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    load_req = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    sel      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state, and a byte offered while idle is not taken
    chk("rst_in_ready", 32'(in_ready8), 32'd0);
    chk("rst_wr_en", 32'(wr_en8), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr8), 32'd0);
    chk("rst_wr_data", 32'(wr_data8), 32'd0);
    chk("rst_proc_reset", 32'(proc_reset8), 32'd1);
    chk("rst_start", 32'(start8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_error", 32'(error8), 32'd0);
    chk("rst_words", 32'(words8), 32'd0);
    in_data  = 8'h5A;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready8), 32'd0);
      chk("idle_busy", 32'(busy8), 32'd0);
    end
    in_valid = 1'b0;

    // Two-word program, valid held high
    prog = '{16'h1234, 16'hABCD};
    run_load(8'h02, 1'b0);
    wait_idle();
    check_ok_load("basic", 2);

    // Same program, valid toggling, load_req poked while busy
    toggle_mode = 1;
    poke_req    = 1;
    run_load(8'h02, 1'b0);
    wait_idle();
    check_ok_load("toggle", 2);
    toggle_mode = 0;
    poke_req    = 0;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Corrupt checksum: words still written, processor stays held
    run_load(8'h02, 1'b1);
    wait_idle();
    chk("bad_ck_starts", start_cnt, 32'd0);
    chk("bad_ck_error", 32'(c_error), 32'd1);
    chk("bad_ck_done", 32'(c_done), 32'd0);
    chk("bad_ck_proc_reset", 32'(c_pr), 32'd1);
    chk("bad_ck_all_written", 32'(exp_q.size()), 32'd0);
`endif

    // Count 0 on the 16-deep instance loads exactly 16 words
    sel = 1'b1;
    @(negedge clk);
    prev_pr = c_pr;
    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back(16'(16'hC000 + i * 16'h0111));
    run_load(8'h00, 1'b0);
    wait_idle();
    check_ok_load("full_depth", 16);
    repeat (4) @(negedge clk);
    chk("full_depth_no_extra", 32'(exp_q.size()), 32'd0);

    // Reset after the first high byte aborts the load
    sel = 1'b0;
    @(negedge clk);
    prev_pr = c_pr;
    pulse_load();
    send_byte(8'h02);
    send_byte(8'h12);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_proc_reset", 32'(proc_reset8), 32'd1);
    chk("abort_in_ready", 32'(in_ready8), 32'd0);
    chk("abort_words", 32'(words8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_wr_en", 32'(wr_en8), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    prev_pr = 1'b1;
    exp_q.delete();
    @(negedge clk);
    prog = '{16'h0007};
    run_load(8'h01, 1'b0);
    wait_idle();
    check_ok_load("after_abort", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
